uart_boot_loader: RTL

Parametrised program loader replacing the fixed-width ICCM controller and programming UART receiver pair. It receives framed images over a serial line at a run-time baud divisor and assembles little-endian words of configurable width. Words are written into one of several selectable memory targets (ICCM, DCCM, …), with a checksum per frame. The system is held in reset until a terminating frame arrives. It sits between the `uart_rx` pad and the memory adapters' controller write ports, next to the reset manager.

---
 rtl/uart_boot_loader.sv | 315 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_boot_loader.sv
// Serial program loader: 8N1 receiver plus frame parser that writes little-endian words into
// one of NUM_TGT memories and holds the system in reset until a terminator frame arrives.
module uart_boot_loader #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned BAUD_W  = 16,
  parameter int unsigned NUM_TGT = 2,
  localparam int unsigned TGT_W  = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              prog_i,
  input  logic [BAUD_W-1:0] clks_per_bit_i,
  input  logic              rx_i,
  output logic              we_o,
  output logic [TGT_W-1:0]  tgt_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              hold_rst_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [2:0]        err_o
);

  localparam int unsigned NBYTES = DATA_W / 8;
  localparam int unsigned BC_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [BC_W-1:0] LastByte = BC_W'(NBYTES - 1);
  localparam logic [8:0] NumTgtB = 9'(NUM_TGT);

  // ---------------------------------------------------------------------------------------------
  // Input synchroniser and prog_i edge detection
  // ---------------------------------------------------------------------------------------------
  logic rx_meta_q, rx_sync_q, rx_prev_q, prog_q;
  logic prog_rise, prog_fall;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      prog_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      prog_q    <= prog_i;
    end
  end

  assign prog_rise = prog_i & ~prog_q;
  assign prog_fall = ~prog_i & prog_q;

  // ---------------------------------------------------------------------------------------------
  // Byte receiver
  // ---------------------------------------------------------------------------------------------
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  rx_state_e         rx_state_q, rx_state_d;
  logic [BAUD_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]        rx_bit_q, rx_bit_d;
  logic [7:0]        rx_shift_q, rx_shift_d;
  logic              rx_dv, rx_ferr;
  logic [BAUD_W-1:0] half_bit;
  logic              bit_end;

  assign half_bit = clks_per_bit_i >> 1;
  assign bit_end  = (rx_cnt_q == clks_per_bit_i - BAUD_W'(1));

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_dv      = 1'b0;
    rx_ferr    = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RxStart;
          rx_cnt_d   = '0;
        end
      end
      RxStart: begin
        // A start bit that is high again at mid-bit was a glitch
        if (rx_cnt_q == half_bit - BAUD_W'(1)) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? RxIdle : RxData;
        end else begin
          rx_cnt_d = rx_cnt_q + BAUD_W'(1);
        end
      end
      RxData: begin
        if (bit_end) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RxStop;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + BAUD_W'(1);
        end
      end
      RxStop: begin
        if (bit_end) begin
          rx_state_d = RxIdle;
          rx_dv      = rx_sync_q;
          rx_ferr    = ~rx_sync_q;
        end else begin
          rx_cnt_d = rx_cnt_q + BAUD_W'(1);
        end
      end
    endcase
    if (prog_rise) begin
      rx_state_d = RxIdle;
      rx_dv      = 1'b0;
      rx_ferr    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Frame parser
  // ---------------------------------------------------------------------------------------------
  typedef enum logic [2:0] {
    StSync, StTgt, StLen0, StLen1, StBase0, StBase1, StData, StCsum
  } state_e;

  state_e            state_q, state_d;
  logic [TGT_W-1:0]  tgt_lat_q, tgt_lat_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       words_left_q, words_left_d;
  logic [7:0]        base_lo_q, base_lo_d;
  logic [ADDR_W-1:0] addr_cur_q, addr_cur_d;
  logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [DATA_W-1:0] word_q, word_d, word_next;
  logic [7:0]        csum_q, csum_d;
  logic              we_q, we_d;
  logic [TGT_W-1:0]  tgt_q, tgt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              done_q, done_d;
  logic [2:0]        err_q, err_d;
  logic [7:0]        rx_byte;

  assign rx_byte = rx_shift_q;

  // Bytes enter at the top so the first byte ends up least significant
  if (DATA_W == 8) begin : g_word_8
    assign word_next = rx_byte;
  end else begin : g_word_wide
    assign word_next = {rx_byte, word_q[DATA_W-1:8]};
  end

  always_comb begin
    state_d      = state_q;
    tgt_lat_d    = tgt_lat_q;
    len_d        = len_q;
    words_left_d = words_left_q;
    base_lo_d    = base_lo_q;
    addr_cur_d   = addr_cur_q;
    byte_cnt_d   = byte_cnt_q;
    word_d       = word_q;
    csum_d       = csum_q;
    we_d         = 1'b0;
    tgt_d        = tgt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    done_d       = done_q;
    err_d        = err_q;

    if (prog_rise) begin
      state_d = StSync;
      done_d  = 1'b0;
      err_d   = '0;
    end else if (prog_fall) begin
      state_d = StSync;
    end else begin
      if (rx_ferr) begin
        err_d[0] = 1'b1;
        state_d  = StSync;
      end
      // The parser keeps running with prog_i low so a terminator can release reset;
      // only the memory writes are gated by prog_i.
      if (rx_dv) begin
        if (state_q != StSync && state_q != StCsum) begin
          csum_d = csum_q ^ rx_byte;
        end
        unique case (state_q)
          StSync: begin
            if (rx_byte == 8'hA5) begin
              csum_d  = '0;
              state_d = StTgt;
            end
          end
          StTgt: begin
            if ({1'b0, rx_byte} >= NumTgtB) begin
              err_d[2] = 1'b1;
              state_d  = StSync;
            end else begin
              tgt_lat_d = rx_byte[TGT_W-1:0];
              state_d   = StLen0;
            end
          end
          StLen0: begin
            len_d[7:0] = rx_byte;
            state_d    = StLen1;
          end
          StLen1: begin
            len_d[15:8] = rx_byte;
            state_d     = StBase0;
          end
          StBase0: begin
            base_lo_d = rx_byte;
            state_d   = StBase1;
          end
          StBase1: begin
            addr_cur_d   = ADDR_W'({rx_byte, base_lo_q});
            words_left_d = len_q;
            byte_cnt_d   = '0;
            state_d      = (len_q == 16'd0) ? StCsum : StData;
          end
          StData: begin
            word_d = word_next;
            if (byte_cnt_q == LastByte) begin
              byte_cnt_d   = '0;
              addr_cur_d   = addr_cur_q + ADDR_W'(1);
              words_left_d = words_left_q - 16'd1;
              if (prog_i) begin
                we_d    = 1'b1;
                tgt_d   = tgt_lat_q;
                addr_d  = addr_cur_q;
                wdata_d = word_next;
              end
              if (words_left_q == 16'd1) begin
                state_d = StCsum;
              end
            end else begin
              byte_cnt_d = byte_cnt_q + BC_W'(1);
            end
          end
          StCsum: begin
            if (rx_byte != csum_q) begin
              err_d[1] = 1'b1;
            end else if (len_q == 16'd0) begin
              done_d = 1'b1;
            end
            state_d = StSync;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StSync;
      tgt_lat_q    <= '0;
      len_q        <= '0;
      words_left_q <= '0;
      base_lo_q    <= '0;
      addr_cur_q   <= '0;
      byte_cnt_q   <= '0;
      word_q       <= '0;
      csum_q       <= '0;
      we_q         <= 1'b0;
      tgt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      done_q       <= 1'b0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      tgt_lat_q    <= tgt_lat_d;
      len_q        <= len_d;
      words_left_q <= words_left_d;
      base_lo_q    <= base_lo_d;
      addr_cur_q   <= addr_cur_d;
      byte_cnt_q   <= byte_cnt_d;
      word_q       <= word_d;
      csum_q       <= csum_d;
      we_q         <= we_d;
      tgt_q        <= tgt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign we_o       = we_q;
  assign tgt_o      = tgt_q;
  assign addr_o     = addr_q;
  assign wdata_o    = wdata_q;
  assign busy_o     = (state_q != StSync);
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign hold_rst_o = prog_i | ~done_q;

endmodule
